// File: rtl/if_id_pipe_reg_if.sv
// IF/ID stage bus: fetch-side valid/ready handshake with flush, and the
// decode-side valid/ready handshake carrying PC+1 and the instruction.
`ifndef INSTRUCTION_LEN
`define INSTRUCTION_LEN 32
`endif
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif

interface if_id_pipe_reg_if #(
  parameter int INSTR_W = `INSTRUCTION_LEN,
  parameter int ADDR_W  = `ADDRESS_LEN
);
  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  in_pc_plus1;
  logic [INSTR_W-1:0] in_instruction;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_pc_plus1;
  logic [INSTR_W-1:0] out_instruction;

  // Surrounding pipeline: drives fetch data, flush and decode ready.
  modport master (
    output in_valid, in_pc_plus1, in_instruction, flush, out_ready,
    input  in_ready, out_valid, out_pc_plus1, out_instruction
  );

  // Pipeline register itself.
  modport slave (
    input  in_valid, in_pc_plus1, in_instruction, flush, out_ready,
    output in_ready, out_valid, out_pc_plus1, out_instruction
  );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake, a one-entry skid
// buffer (so in_ready comes straight from a flop) and a squashing flush.
// An empty or squashed stage presents NOP_INSTR toward decode.
`ifndef INSTRUCTION_LEN
`define INSTRUCTION_LEN 32
`endif
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif

module if_id_pipe_reg #(
  parameter int                 INSTR_W   = `INSTRUCTION_LEN,
  parameter int                 ADDR_W    = `ADDRESS_LEN,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
  input  logic           clk,
  input  logic           rst,
  if_id_pipe_reg_if.slave bus
);

  // Main entry (drives decode) and skid entry (overflow while decode stalls).
  logic               m_valid_r;
  logic [ADDR_W-1:0]  m_pc_r;
  logic [INSTR_W-1:0] m_instr_r;
  logic               s_valid_r;
  logic [ADDR_W-1:0]  s_pc_r;
  logic [INSTR_W-1:0] s_instr_r;

  // Output-side registers, precomputed from next state so outputs are flops.
  logic               in_ready_r;
  logic [INSTR_W-1:0] out_instr_r;

  logic               m_valid_nxt_s;
  logic [ADDR_W-1:0]  m_pc_nxt_s;
  logic [INSTR_W-1:0] m_instr_nxt_s;
  logic               s_valid_nxt_s;
  logic [ADDR_W-1:0]  s_pc_nxt_s;
  logic [INSTR_W-1:0] s_instr_nxt_s;

  logic               accept_s;
  logic               drain_s;

  assign accept_s = bus.in_valid & in_ready_r;
  assign drain_s  = m_valid_r & bus.out_ready;

  // Next-state selection for the main and skid entries.
  always_comb begin
    m_valid_nxt_s = m_valid_r;
    m_pc_nxt_s    = m_pc_r;
    m_instr_nxt_s = m_instr_r;
    s_valid_nxt_s = s_valid_r;
    s_pc_nxt_s    = s_pc_r;
    s_instr_nxt_s = s_instr_r;

    if (bus.flush) begin
      // Squash everything held and anything offered this cycle.
      m_valid_nxt_s = 1'b0;
      m_pc_nxt_s    = {ADDR_W{1'b0}};
      m_instr_nxt_s = NOP_INSTR;
      s_valid_nxt_s = 1'b0;
    end else if (!m_valid_r || drain_s) begin
      // Main slot frees up this cycle.
      if (s_valid_r) begin
        // Older skid entry goes first; in_ready was low so nothing new arrives.
        m_valid_nxt_s = 1'b1;
        m_pc_nxt_s    = s_pc_r;
        m_instr_nxt_s = s_instr_r;
        s_valid_nxt_s = 1'b0;
      end else if (accept_s) begin
        m_valid_nxt_s = 1'b1;
        m_pc_nxt_s    = bus.in_pc_plus1;
        m_instr_nxt_s = bus.in_instruction;
      end else if (drain_s) begin
        // Data is left in place; the output mux shows NOP_INSTR while empty.
        m_valid_nxt_s = 1'b0;
      end else begin
        m_valid_nxt_s = m_valid_r;
      end
    end else begin
      // Main is stalled: a newly accepted entry parks in the skid.
      if (accept_s) begin
        s_valid_nxt_s = 1'b1;
        s_pc_nxt_s    = bus.in_pc_plus1;
        s_instr_nxt_s = bus.in_instruction;
      end else begin
        s_valid_nxt_s = s_valid_r;
      end
    end
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_r   <= 1'b0;
      m_pc_r      <= {ADDR_W{1'b0}};
      m_instr_r   <= NOP_INSTR;
      s_valid_r   <= 1'b0;
      s_pc_r      <= {ADDR_W{1'b0}};
      s_instr_r   <= {INSTR_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_instr_r <= NOP_INSTR;
    end else begin
      m_valid_r   <= m_valid_nxt_s;
      m_pc_r      <= m_pc_nxt_s;
      m_instr_r   <= m_instr_nxt_s;
      s_valid_r   <= s_valid_nxt_s;
      s_pc_r      <= s_pc_nxt_s;
      s_instr_r   <= s_instr_nxt_s;
      in_ready_r  <= ~s_valid_nxt_s;
      out_instr_r <= m_valid_nxt_s ? m_instr_nxt_s : NOP_INSTR;
    end
  end

  assign bus.in_ready        = in_ready_r;
  assign bus.out_valid       = m_valid_r;
  assign bus.out_pc_plus1    = m_pc_r;
  assign bus.out_instruction = out_instr_r;

endmodule
